// File: rtl/clz_iter.sv
// Iterative count-leading-zeros / count-leading-ones unit for CLZ and CLO.
// Scans STEP bits per cycle from the MSB and stops at the first chunk holding the target bit.
module clz_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] data_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("clz_iter: STEP must lie in 1..WIDTH and divide WIDTH");
  end
  if ((STEP & (STEP - 1)) != 0) begin : g_step_pow2
    $error("clz_iter: STEP must be a power of two");
  end
  if (OUT_W < CW) begin : g_bad_out_w
    $error("clz_iter: OUT_W too narrow for a count of 0..WIDTH");
  end

  // Handshake: start is accepted only in IDLE or DONE (mode/data_in captured
  // on that edge); busy is high for every SCAN cycle; done pulses for exactly
  // one cycle and data_out is valid from that cycle until the next done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             out_load;

  logic [STEP-1:0]  chunk;
  logic             chunk_nz;
  logic [CW-1:0]    chunk_lz;
  logic [CW-1:0]    cnt_step;
  logic [CW-1:0]    cnt_hit;
  logic [WIDTH-1:0] load_val;

  // CLO is CLZ of the inverted operand, so the scan only ever looks for a 1.
  assign load_val = mode ? ~data_in : data_in;
  assign chunk    = sr[WIDTH-1 -: STEP];
  assign chunk_nz = |chunk;

  // Leading zeros within a nonzero chunk; the highest set bit wins.
  always_comb begin
    chunk_lz = '0;
    for (int i = 0; i < STEP; i++) begin
      if (chunk[i]) chunk_lz = CW'(STEP - 1 - i);
    end
  end

  assign cnt_step = cnt + CW'(STEP);
  assign cnt_hit  = cnt + chunk_lz;

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    out_load  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          sr_nxt    = load_val;
          cnt_nxt   = '0;
          state_nxt = S_SCAN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (chunk_nz) begin
          cnt_nxt   = cnt_hit;
          out_load  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt_step;
          sr_nxt  = sr << STEP;
          // Only whole chunks are added, so the count lands exactly on WIDTH.
          if (cnt_step == CW'(WIDTH)) begin
            out_load  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sr       <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      if (out_load) data_out <= OUT_W'(cnt_nxt);
    end
  end

  assign busy = (state == S_SCAN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_clz_iter.sv
// Scoreboard bench for clz_iter: results and latencies are queued at issue
// and compared when done pulses.
module tb_clz_iter;
  localparam int WIDTH  = 32;
  localparam int STEP   = 4;
  localparam int OUT_W  = 32;
  localparam int NCHUNK = WIDTH / STEP;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] data_out;

  logic [OUT_W-1:0] exp_q[$];
  int               lat_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [OUT_W-1:0] last_out;

  always #5 clk = ~clk;

  clz_iter #(.WIDTH(WIDTH), .STEP(STEP), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int ref_lead(input logic [WIDTH-1:0] d, input logic m);
    logic [WIDTH-1:0] v;
    v = m ? ~d : d;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) return WIDTH - 1 - i;
    end
    return WIDTH;
  endfunction

  function automatic int ref_lat(input int n);
    int l;
    l = n / STEP + 1;
    if (l > NCHUNK) l = NCHUNK;
    return l;
  endfunction

  // Drives one start pulse; the caller makes sure the unit can accept.
  task automatic issue(input logic [WIDTH-1:0] d, input logic m, input bit track);
    start   = 1'b1;
    mode    = m;
    data_in = d;
    if (track) begin
      exp_q.push_back(OUT_W'(ref_lead(d, m)));
      lat_q.push_back(ref_lat(ref_lead(d, m)));
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = $urandom;
    mode    = 1'($urandom_range(0, 1));
  endtask

  // Returns at the falling edge of the done cycle.
  task automatic wait_done(input int spent);
    int               scan;
    bit               seen;
    logic [OUT_W-1:0] e;
    int               el;
    scan = spent;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        check("busy_in_scan", busy, 1);
        check("out_hold_scan", data_out, last_out);
        scan++;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
      end
      return;
    end
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check("result", data_out, e);
    check("latency", scan, el);
    check("busy_at_done", busy, 0);
    last_out = e;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] d, input logic m);
    @(negedge clk);
    issue(d, m, 1'b1);
    wait_done(0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("out_hold_idle", data_out, last_out);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             m;

    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    data_in  = '0;
    last_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", data_out, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_done", done, 0);
      check("idle_busy", busy, 0);
    end

    // Directed CLZ / CLO operands
    run_op(32'h8000_0000, 1'b0);
    run_op(32'h0001_0000, 1'b0);
    run_op(32'h0000_0000, 1'b0);
    run_op(32'h0000_0001, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b1);
    run_op(32'hF0F0_0000, 1'b1);
    run_op(32'h7FFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFF, 1'b0);
    run_op(32'h0000_0000, 1'b1);
    run_op(32'hFFFF_FFFE, 1'b1);

    // start pulse and operand change mid-scan are ignored
    @(negedge clk);
    issue(32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk);
    check("mid_busy1", busy, 1);
    start   = 1'b1;
    data_in = 32'h8000_0000;
    mode    = 1'b1;
    @(negedge clk);
    check("mid_busy2", busy, 1);
    start = 1'b0;
    wait_done(2);

    // Back-to-back issue from the DONE cycle
    @(negedge clk);
    issue(32'h0000_0100, 1'b0, 1'b1);
    wait_done(0);
    for (int i = 0; i < 4; i++) begin
      m = 1'($urandom_range(0, 1));
      d = $urandom >> $urandom_range(0, 32);
      issue(m ? ~d : d, m, 1'b1);
      wait_done(0);
    end
    @(negedge clk);
    check("b2b_idle", busy, 0);

    // Reset during the third scan cycle abandons the operation
    @(negedge clk);
    issue(32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_out", data_out, 0);
    rst      = 1'b0;
    last_out = '0;
    repeat (10) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    run_op(32'h0000_0400, 1'b0);

    // Simultaneous reset and start: start is dropped
    @(negedge clk);
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 32'h0000_0010;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_out", data_out, 0);
    last_out = '0;
    @(negedge clk);
    check("rst_start_idle", busy, 0);

    // Random operands, biased towards long runs of leading zeros/ones
    repeat (150) begin
      m = 1'($urandom_range(0, 1));
      d = $urandom >> $urandom_range(0, 32);
      run_op(m ? ~d : d, m);
    end

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clz_iter.md
Name: clz_iter

Overview:
- Iterative count-leading-zeros / count-leading-ones unit for the multi-cycle CPU datapath, serving the CLZ and CLO instructions.
- Scans the operand STEP bits per cycle from the MSB and stops early at the first chunk containing the target bit.
- Handshakes with the control FSM through start/busy/done, so the CPU stalls its execute state only as long as needed.
- The result is zero-extended to OUT_W for direct register-file write-back.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of STEP.
- STEP, 4, bits examined per SCAN cycle; power of two, 1..WIDTH.
- OUT_W, 32, result width; must satisfy OUT_W >= $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when the unit is able to accept.
- mode  input  1  0 = CLZ (count leading 0s), 1 = CLO (count leading 1s); sampled with start.
- data_in  input  WIDTH  operand; sampled with start.
- busy  output  1  high while in SCAN.
- done  output  1  single-cycle pulse; data_out is valid from this cycle onward.
- data_out  output  OUT_W  leading-bit count, 0..WIDTH, zero-extended.

Behaviour:
- Reset: synchronous, active-high; dominates all other inputs.
  - State goes to IDLE.
  - busy=0, done=0, data_out=0.
  - Shift register and count are cleared.
  - A reset mid-SCAN abandons the operation with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1: load shift register with data_in (CLZ) or ~data_in (CLO); clear count; go to SCAN.
  - Otherwise stay in IDLE.
- SCAN: examine the top STEP bits of the shift register (chunk).
  - If the chunk is nonzero: count += leading zeros within the chunk (0..STEP-1); go to DONE.
  - If the chunk is zero: count += STEP; shift the register left by STEP.
    - If count has now reached WIDTH, go to DONE.
    - Otherwise stay in SCAN.
  - busy=1 throughout SCAN.
  - start is ignored while in SCAN.
- DONE:
  - done=1 for exactly this cycle; data_out is updated with count on entry to DONE.
  - If start=1 in DONE, the new operation is accepted and the unit goes directly to SCAN (back-to-back issue).
  - Otherwise the unit goes to IDLE.
- data_out holds its value through IDLE and through any subsequent SCAN until the next DONE; it never shows partial counts.
- Latency:
  - k = index (1-based) of the first chunk containing the target bit, or WIDTH/STEP if there is none.
  - The edge sampling start is E0; done is high in the cycle after edge Ek.
  - Minimum latency is 1 scan cycle; maximum is WIDTH/STEP.
- Arithmetic and width rules:
  - count is $clog2(WIDTH)+1 bits wide and saturates exactly at WIDTH; no wrap-around.
  - The all-zero operand (CLZ) or all-ones operand (CLO) yields WIDTH.
- mode and data_in are captured at start; changes to them during SCAN have no effect.
- Simultaneous rst and start: rst wins, and start is dropped.

Test Plan:
- Reset, then idle: rst for 2 cycles -> busy=0, done=0, data_out=0; no done pulse while start stays low.
- CLZ, early exit: mode=0, data_in=0x8000_0000, start -> done after 1 scan cycle, data_out=0. Then data_in=0x0001_0000 -> 4 scan cycles, data_out=15.
- CLZ, full scan: data_in=0x0000_0000 -> busy high for 8 cycles, done pulse, data_out=32. Then data_in=0x0000_0001 -> 8 cycles, data_out=31.
- CLO mode:
  - 0xFFFF_FFFF -> data_out=32 after 8 cycles.
  - 0xF0F0_0000 -> data_out=4 after 2 cycles.
  - 0x7FFF_FFFF -> data_out=0 after 1 cycle.
- Handshake:
  - start pulsed during SCAN and data_in changed mid-scan -> both ignored; the result matches the original operand.
  - start asserted in the DONE cycle -> the new operation begins with no IDLE cycle, and its result is correct.
- Reset mid-operation: rst during the 3rd SCAN cycle of a 0x0 operand -> next cycle is IDLE with busy=0, data_out=0, and no done pulse. A following operation returns the correct result.
- Parameter sweep (additional coverage beyond the directed scenarios): WIDTH=32 with STEP=1, 8 and 32 -> results identical to STEP=4 on 1000 random operands plus the above corner operands. Latency must equal ceil((clz+1)/STEP), capped at WIDTH/STEP.
